reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
- Board-level reset controller for the VGA design.
- Waits for a stable PLL lock, then drives the global set/reset (gsr_out), preload (prld_out) and global tristate (gts_out) releases in a fixed order.
- Then releases per-domain resets one stage at a time.
- Also arbitrates soft-reset requests from several requesters and replays the sequence for each granted request.

Parameters:
GSR_CYCLES, 100, cycles gsr_out/prld_out stay high in GSR state (>=1)
GTS_CYCLES, 8, cycles gts_out stays high after GSR release (>=1)
STAGE_CYCLES, 4, cycles between successive domain reset releases (>=1)
NUM_DOMAINS, 3, number of downstream reset domains (>=1)
LOCK_FILTER, 16, consecutive synced-lock-high cycles required (>=1)
NUM_REQ, 2, number of soft-reset requesters (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
pll_locked  in  1  PLL lock, asynchronous to clk
soft_req  in  NUM_REQ  level soft-reset requests; requester holds high until acked
soft_ack  out  NUM_REQ  one-cycle grant pulse, one-hot
gsr_out  out  1  global set/reset, active-high
prld_out  out  1  preload, active-high, identical timing to gsr_out
gts_out  out  1  global tristate, active-high
dom_rst  out  NUM_DOMAINS  per-domain resets, active-high
ready  out  1  high only in RUN
busy  out  1  high in GSR, GTS or DOM

Behaviour:
Reset and outputs
- rst asserted (async): state=HOLD; gsr_out=prld_out=gts_out=1; dom_rst=all 1; ready=0; busy=0; soft_ack=0; RR pointer=0; all counters=0; lock sync flops=0.
- All outputs registered. No combinational path from any input to any output.

Lock qualification
- pll_locked passes through a 2-FF synchronizer.
- Filter counter increments while the synced value is 1 and clears to 0 when it is 0.
- Filtered lock is true once the counter reaches LOCK_FILTER; the counter saturates there.

State machine: HOLD -> GSR -> GTS -> DOM -> RUN
- HOLD: all resets asserted. Go to GSR when filtered lock is true.
- GSR: gsr_out/prld_out high for exactly GSR_CYCLES cycles in this state. Both drop on the GSR->GTS transition edge.
- GTS: gts_out high for GTS_CYCLES further cycles, then drops on the GTS->DOM edge.
- DOM: dom_rst[0] releases STAGE_CYCLES cycles after DOM entry; each next index releases STAGE_CYCLES later. Release of dom_rst[NUM_DOMAINS-1] and entry to RUN happen on the same edge.
- RUN: ready=1. All resets stay deasserted.
- Release order is fixed: GSR/PRLD first, then GTS, then domains in ascending index. Reassertion is always simultaneous.

Lock loss
- Filtered lock false in any state other than HOLD: next edge goes to HOLD and reasserts every reset; ready=0.
- Lock loss wins over everything else.

Soft reset
- Requests are sampled only in RUN with filtered lock true.
- A round-robin arbiter picks the first set soft_req at or after the RR pointer, wrapping around.
- On that edge: soft_ack[winner]=1 for one cycle; RR pointer=winner+1 mod NUM_REQ; state goes to GSR with all resets reasserted. The lock wait is skipped.
- Requests raised outside RUN stay pending and are not acked until RUN is reached.
- A still-pending request is served after the replay completes.
- Lock loss in the same cycle as a request: go to HOLD, no ack.

Counters
- Stage counter width is $clog2(max(GSR_CYCLES,GTS_CYCLES,STAGE_CYCLES)+1). It clears on every state entry.
- Domain index counter width is $clog2(NUM_DOMAINS+1).
- No wrap is possible: every counter is bounded by its terminal compare.

Decomposition:
- Shared package holds:
  - state enum (HOLD, GSR, GTS, DOM, RUN)
  - default timing constants
  - a function computing counter widths
- One sub-module: rr_arbiter (NUM_REQ wide). Inputs: req, enable. Outputs: one-hot grant. Owns the RR pointer.
- The 2-FF synchronizer and the lock filter stay inline.

Test Plan:
- Power-up, defaults: pll_locked=1 from t=0 after rst release.
  - GSR entry at cycle 18: 2 sync + 16 filter.
  - gsr_out/prld_out fall at cycle 118; gts_out falls at 126.
  - dom_rst[0..2] fall at 130/134/138; ready=1 at 138.
- Lock glitch: pll_locked drops for 1 cycle at filter count 10 -> filter restarts; GSR entry is delayed by 11+ cycles; gsr_out never drops early.
- Lock loss mid-DOM: drop pll_locked after dom_rst[0] release -> 3 cycles later (sync+filter clear) all resets are high and ready=0. Restore lock -> full sequence from HOLD.
- Soft reset in RUN: soft_req=2'b01 -> soft_ack=01 pulse for 1 cycle and gsr_out=1 on the same edge. ready returns 120 cycles later.
- Round-robin: soft_req=2'b11 held across replays -> acks in order req0, req1, req0. Each ack occurs only on RUN entry.
- rst mid-GTS: assert rst asynchronously -> gsr_out/gts_out/dom_rst=1 and ready=0 with no clock edge; state=HOLD after release.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the board reset sequencer: state codes, default
// timing and counter-width helpers.
package reset_sequencer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_HOLD = 3'd0;
  localparam state_t ST_GSR  = 3'd1;
  localparam state_t ST_GTS  = 3'd2;
  localparam state_t ST_DOM  = 3'd3;
  localparam state_t ST_RUN  = 3'd4;

  localparam int DEF_GSR_CYCLES   = 100;
  localparam int DEF_GTS_CYCLES   = 8;
  localparam int DEF_STAGE_CYCLES = 4;
  localparam int DEF_NUM_DOMAINS  = 3;
  localparam int DEF_LOCK_FILTER  = 16;
  localparam int DEF_NUM_REQ      = 2;

  // Width able to hold the largest of three terminal counts.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    else       m = m;
    if (c > m) m = c;
    else       m = m;
    return $clog2(m + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_rr_arbiter.sv
// Round-robin soft-reset arbiter: one-hot grant from the first request at or
// after the pointer; the pointer moves past the winner only on a grant.
module rr_arbiter
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_enable,
  output logic [NUM_REQ-1:0] o_grant
);

  localparam int PW = idx_width(NUM_REQ);

  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      w_win;
  logic               w_found;
  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_pick;
  int                 w_pos;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_pos   = 0;
    w_mask  = '0;
    w_pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_pos  = (int'(r_ptr) + i) % NUM_REQ;
      w_mask = NUM_REQ'(1) << w_pos;
      if (!w_found && (|(i_req & w_mask))) begin
        w_found = 1'b1;
        w_win   = PW'(w_pos);
        w_pick  = w_mask;
      end else begin
        w_found = w_found;
      end
    end
    if (i_enable && w_found) o_grant = w_pick;
    else                     o_grant = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_enable && w_found) begin
      r_ptr <= (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Board reset controller: qualifies PLL lock, releases GSR/PRLD, GTS and the
// domain resets in order, and replays the sequence for granted soft resets.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int GSR_CYCLES   = DEF_GSR_CYCLES,
  parameter int GTS_CYCLES   = DEF_GTS_CYCLES,
  parameter int STAGE_CYCLES = DEF_STAGE_CYCLES,
  parameter int NUM_DOMAINS  = DEF_NUM_DOMAINS,
  parameter int LOCK_FILTER  = DEF_LOCK_FILTER,
  parameter int NUM_REQ      = DEF_NUM_REQ
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic [NUM_REQ-1:0]     soft_req,
  output logic [NUM_REQ-1:0]     soft_ack,
  output logic                   gsr_out,
  output logic                   prld_out,
  output logic                   gts_out,
  output logic [NUM_DOMAINS-1:0] dom_rst,
  output logic                   ready,
  output logic                   busy
);

  localparam int SW = cnt_width(GSR_CYCLES, GTS_CYCLES, STAGE_CYCLES);
  localparam int DW = cnt_width(NUM_DOMAINS, 0, 0);
  localparam int FW = cnt_width(LOCK_FILTER, 0, 0);

  localparam logic [SW-1:0] GSR_LAST = SW'(GSR_CYCLES - 1);
  localparam logic [SW-1:0] GTS_LAST = SW'(GTS_CYCLES - 1);
  localparam logic [SW-1:0] STG_LAST = SW'(STAGE_CYCLES - 1);
  localparam logic [DW-1:0] DOM_LAST = DW'(NUM_DOMAINS - 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(LOCK_FILTER);

  logic                   r_sync1, r_sync2;
  logic [FW-1:0]          r_filt;
  state_t                 r_state;
  logic [SW-1:0]          r_stg;
  logic [DW-1:0]          r_idx;
  logic [NUM_REQ-1:0]     r_ack;
  logic                   r_gsr, r_gts, r_ready, r_busy;
  logic [NUM_DOMAINS-1:0] r_dom;
  logic                   w_lock_ok;
  logic [NUM_REQ-1:0]     w_grant;

  assign w_lock_ok = (r_filt == FILT_MAX);

  assign soft_ack = r_ack;
  assign gsr_out  = r_gsr;
  assign prld_out = r_gsr;
  assign gts_out  = r_gts;
  assign dom_rst  = r_dom;
  assign ready    = r_ready;
  assign busy     = r_busy;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    (soft_req),
    .i_enable ((r_state == ST_RUN) && w_lock_ok),
    .o_grant  (w_grant)
  );

  // Lock synchronizer and saturating consecutive-high filter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_filt  <= '0;
    end else begin
      r_sync1 <= pll_locked;
      r_sync2 <= r_sync1;
      if (!r_sync2)              r_filt <= '0;
      else if (r_filt != FILT_MAX) r_filt <= r_filt + 1'b1;
      else                       r_filt <= r_filt;
    end
  end

  // Sequencer FSM; lock loss overrides everything, including soft requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_HOLD;
      r_stg   <= '0;
      r_idx   <= '0;
      r_ack   <= '0;
      r_gsr   <= 1'b1;
      r_gts   <= 1'b1;
      r_dom   <= '1;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else if (!w_lock_ok) begin
      r_state <= ST_HOLD;
      r_stg   <= '0;
      r_idx   <= '0;
      r_ack   <= '0;
      r_gsr   <= 1'b1;
      r_gts   <= 1'b1;
      r_dom   <= '1;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ack <= '0;
      case (r_state)
        ST_HOLD: begin
          r_state <= ST_GSR;
          r_stg   <= '0;
          r_busy  <= 1'b1;
        end
        ST_GSR: begin
          if (r_stg == GSR_LAST) begin
            r_state <= ST_GTS;
            r_stg   <= '0;
            r_gsr   <= 1'b0;
          end else begin
            r_stg <= r_stg + 1'b1;
          end
        end
        ST_GTS: begin
          if (r_stg == GTS_LAST) begin
            r_state <= ST_DOM;
            r_stg   <= '0;
            r_idx   <= '0;
            r_gts   <= 1'b0;
          end else begin
            r_stg <= r_stg + 1'b1;
          end
        end
        ST_DOM: begin
          if (r_stg == STG_LAST) begin
            r_stg <= '0;
            r_dom <= r_dom & ~(NUM_DOMAINS'(1) << r_idx);
            if (r_idx == DOM_LAST) begin
              r_state <= ST_RUN;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_stg <= r_stg + 1'b1;
          end
        end
        ST_RUN: begin
          if (|w_grant) begin
            r_ack   <= w_grant;
            r_state <= ST_GSR;
            r_stg   <= '0;
            r_idx   <= '0;
            r_gsr   <= 1'b1;
            r_gts   <= 1'b1;
            r_dom   <= '1;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_HOLD;
          r_stg   <= '0;
          r_idx   <= '0;
          r_gsr   <= 1'b1;
          r_gts   <= 1'b1;
          r_dom   <= '1;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
